perf_counter_bank: RTL and testbench

Parametrised multi-channel performance-monitor block for the multicycle processor. It counts up to CHANNELS independent event strobes from the datapath and control FSM, such as cycles, IR loads, memory reads/writes and flag writes. Counting runs under a small run-control state machine that freezes on the processor's Stop level. The block snapshots all counters atomically into shadow registers and presents one selected channel for the HEX display muxes. It generalises the single 16-bit cycle counter with configurable width, channel count, overflow mode and start behaviour.

---
 rtl/perf_counter_bank.sv | 119 +++++++++++
 tb/tb_perf_counter_bank.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// Multi-channel performance counter bank with run-control FSM, sticky overflow
// flags and an atomic snapshot into shadow registers for display readout.
module perf_counter_bank #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned CHANNELS   = 4,
   parameter int unsigned SEL_W      = 2,
   parameter bit          SATURATE   = 1'b0,
   parameter bit          AUTO_START = 1'b1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                clear_i,
   input  logic                start_i,
   input  logic                stop_i,
   input  logic [CHANNELS-1:0] event_i,
   input  logic                snap_i,
   input  logic [SEL_W-1:0]    sel_i,
   output logic [WIDTH-1:0]    read_data_o,
   output logic [CHANNELS-1:0] overflow_o,
   output logic [1:0]          state_o,
   output logic                running_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_FROZEN = 2'b10
   } state_e;

   localparam state_e ST_INIT = AUTO_START ? ST_RUN : ST_IDLE;

   state_e                             state_q;
   logic                               running_q;
   logic [CHANNELS-1:0][WIDTH-1:0]     cnt_q, cnt_d;
   logic [CHANNELS-1:0][WIDTH-1:0]     shadow_q;
   logic [CHANNELS-1:0]                ovf_q, ovf_d;
   logic                               count_en;

   // Run-control FSM; running is registered alongside the state it mirrors.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_INIT;
         running_q <= AUTO_START;
      end else if (clear_i) begin
         state_q   <= ST_INIT;
         running_q <= AUTO_START;
      end else begin
         case (state_q)
            ST_IDLE, ST_FROZEN: begin
               if (start_i && !stop_i) begin
                  state_q   <= ST_RUN;
                  running_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (stop_i) begin
                  state_q   <= ST_FROZEN;
                  running_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= ST_INIT;
               running_q <= AUTO_START;
            end
         endcase
      end
   end

   // Counting uses the live stop level, so the freezing edge never counts.
   assign count_en = (state_q == ST_RUN) && !stop_i && !clear_i;

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (clear_i) begin
            cnt_d[i] = '0;
            ovf_d[i] = 1'b0;
         end else if (count_en && event_i[i]) begin
            if (&cnt_q[i]) begin
               ovf_d[i] = 1'b1;
               cnt_d[i] = SATURATE ? cnt_q[i] : '0;
            end else begin
               cnt_d[i] = cnt_q[i] + WIDTH'(1);
            end
         end
      end
   end

   // Shadows take pre-edge counter values, so a snap coinciding with clear
   // or an increment captures the old value.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         ovf_q    <= '0;
         shadow_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         if (snap_i) begin
            shadow_q <= cnt_q;
         end
      end
   end

   always_comb begin
      read_data_o = '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (sel_i == SEL_W'(i)) begin
            read_data_o = shadow_q[i];
         end
      end
   end

   assign overflow_o = ovf_q;
   assign state_o    = state_q;
   assign running_o  = running_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Randomized bench for perf_counter_bank: three configurations share one
// stimulus stream and are compared against an arithmetic reference model.
module tb_perf_counter_bank;

   logic       clock = 1'b0;
   logic       reset;
   logic       clear, start, stop, snap;
   logic [3:0] ev;
   logic [1:0] sel;

   logic [15:0] rd0;
   logic [3:0]  rd1, rd2;
   logic [3:0]  ov0, ov2;
   logic [2:0]  ov1;
   logic [1:0]  st0, st1, st2;
   logic        run0, run1, run2;

   int checks = 0;
   int errors = 0;

   // Per-instance configuration, matching the instantiations below
   int unsigned cfg_w    [3] = '{16, 4, 4};
   int unsigned cfg_ch   [3] = '{4, 3, 4};
   bit          cfg_sat  [3] = '{1'b0, 1'b0, 1'b1};
   bit          cfg_auto [3] = '{1'b1, 1'b0, 1'b1};

   // Reference model: plain integers per instance and channel
   int unsigned m_cnt [3][4];
   int unsigned m_shd [3][4];
   bit          m_ovf [3][4];
   int unsigned m_st  [3];

   always #5 clock = ~clock;

   perf_counter_bank #(.WIDTH(16), .CHANNELS(4), .SEL_W(2), .SATURATE(1'b0), .AUTO_START(1'b1)) u_dut0 (
      .clock(clock), .reset(reset), .clear_i(clear), .start_i(start), .stop_i(stop),
      .event_i(ev), .snap_i(snap), .sel_i(sel),
      .read_data_o(rd0), .overflow_o(ov0), .state_o(st0), .running_o(run0));

   perf_counter_bank #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .SATURATE(1'b0), .AUTO_START(1'b0)) u_dut1 (
      .clock(clock), .reset(reset), .clear_i(clear), .start_i(start), .stop_i(stop),
      .event_i(ev[2:0]), .snap_i(snap), .sel_i(sel),
      .read_data_o(rd1), .overflow_o(ov1), .state_o(st1), .running_o(run1));

   perf_counter_bank #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .SATURATE(1'b1), .AUTO_START(1'b1)) u_dut2 (
      .clock(clock), .reset(reset), .clear_i(clear), .start_i(start), .stop_i(stop),
      .event_i(ev), .snap_i(snap), .sel_i(sel),
      .read_data_o(rd2), .overflow_o(ov2), .state_o(st2), .running_o(run2));

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 4; i++) begin
            m_cnt[k][i] = 0;
            m_shd[k][i] = 0;
            m_ovf[k][i] = 1'b0;
         end
         m_st[k] = cfg_auto[k] ? 1 : 0;
      end
   endtask

   // One rising edge of the model, using the inputs held across that edge
   task automatic model_edge();
      for (int k = 0; k < 3; k++) begin
         int unsigned maxv;
         maxv = (1 << cfg_w[k]) - 1;
         if (snap)
            for (int i = 0; i < 4; i++) m_shd[k][i] = m_cnt[k][i];
         if (clear) begin
            for (int i = 0; i < 4; i++) begin
               m_cnt[k][i] = 0;
               m_ovf[k][i] = 1'b0;
            end
            m_st[k] = cfg_auto[k] ? 1 : 0;
         end else begin
            if (m_st[k] == 1 && !stop) begin
               for (int i = 0; i < int'(cfg_ch[k]); i++) begin
                  if (ev[i]) begin
                     if (m_cnt[k][i] == maxv) begin
                        m_ovf[k][i] = 1'b1;
                        m_cnt[k][i] = cfg_sat[k] ? maxv : 0;
                     end else begin
                        m_cnt[k][i] = m_cnt[k][i] + 1;
                     end
                  end
               end
            end
            if (m_st[k] == 1) begin
               if (stop) m_st[k] = 2;
            end else if (start && !stop) begin
               m_st[k] = 1;
            end
         end
      end
   endtask

   task automatic check_all(input string where);
      for (int k = 0; k < 3; k++) begin
         logic [31:0] a_rd, a_ov, a_st, a_run, e_rd, e_ov;
         case (k)
            0:       begin a_rd = 32'(rd0); a_ov = 32'(ov0); a_st = 32'(st0); a_run = 32'(run0); end
            1:       begin a_rd = 32'(rd1); a_ov = 32'(ov1); a_st = 32'(st1); a_run = 32'(run1); end
            default: begin a_rd = 32'(rd2); a_ov = 32'(ov2); a_st = 32'(st2); a_run = 32'(run2); end
         endcase
         e_ov = 0;
         for (int i = 0; i < int'(cfg_ch[k]); i++)
            if (m_ovf[k][i]) e_ov = e_ov | (32'd1 << i);
         e_rd = (32'(sel) < cfg_ch[k]) ? m_shd[k][sel] : 0;
         check_eq($sformatf("%s d%0d state", where, k), a_st, m_st[k]);
         check_eq($sformatf("%s d%0d running", where, k), a_run, (m_st[k] == 1) ? 1 : 0);
         check_eq($sformatf("%s d%0d overflow", where, k), a_ov, e_ov);
         check_eq($sformatf("%s d%0d read_data sel%0d", where, k, sel), a_rd, e_rd);
      end
   endtask

   task automatic cycle(input string tag, input logic [3:0] e, input logic sp,
                        input logic st, input logic cl, input logic sn, input logic [1:0] sl);
      @(negedge clock);
      ev = e; stop = sp; start = st; clear = cl; snap = sn; sel = sl;
      @(posedge clock);
      model_edge();
      #1;
      check_all(tag);
   endtask

   // Assert reset between edges and require outputs to drop before the next edge
   task automatic async_reset(input string tag);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clock);
      ev = '0; stop = 1'b0; start = 1'b0; clear = 1'b0; snap = 1'b0;
      reset = 1'b0;
   endtask

   initial begin
      logic stp;
      reset = 1'b1;
      clear = 1'b0; start = 1'b0; stop = 1'b0; snap = 1'b0; ev = '0; sel = '0;
      model_reset();
      #3;
      check_all("reset");
      @(negedge clock);
      reset = 1'b0;

      // Auto-start counting, then freeze and snapshot
      for (int i = 0; i < 10; i++) cycle("auto_cnt", 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      for (int i = 0; i < 3; i++)  cycle("frozen", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
      cycle("snap_frozen", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
      cycle("start_stop", 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      cycle("start", 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

      // Independent channels
      cycle("clr", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      cycle("start2", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      for (int i = 0; i < 8; i++)
         cycle("alt", (i % 2 == 0) ? 4'b0101 : 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      cycle("alt_snap", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
      for (int s = 0; s < 4; s++) cycle("alt_read", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'(s));

      // Wrap/saturate with 17 events on channel 0
      cycle("clr3", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      cycle("start3", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      for (int i = 0; i < 17; i++) cycle("ovf_cnt", 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      cycle("ovf_snap", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
      cycle("ovf_read", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

      // Snap colliding with clear after 7 counts on channel 1
      cycle("clr4", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
      cycle("start4", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
      for (int i = 0; i < 7; i++) cycle("pre_col", 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
      cycle("collide", 4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1);
      cycle("post_col", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
      async_reset("rst_mid");

      // Randomized run with one async reset partway through
      stp = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 9) == 0) stp = ~stp;
         cycle("rand", 4'($urandom), stp, ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0), 2'($urandom));
         if (n == 700) begin
            async_reset("rst_rand");
            stp = 1'b0;
         end
      end
      async_reset("rst_end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
